// File: rtl/demosaic_pkg.sv
// Shared definitions for the demosaic datapath: default widths, the product
// word type used by the multiplier wrapper and its consumers, and clog2.
package demosaic_pkg;

    localparam int PROD_W_DEF    = 25;
    localparam int OUT_W_DEF     = 8;
    localparam int SHIFT_DEF     = 10;
    localparam int TERMS_MAX_DEF = 4;

    typedef logic [PROD_W_DEF-1:0] prod_t;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/demosaic_wsum_norm_if.sv
// Valid/ready stream with a group-end marker; used for both the product input
// and the pixel output of the weighted-sum normaliser.
interface demosaic_wsum_norm_if
    import demosaic_pkg::*;
#(
    parameter int W = OUT_W_DEF
);

    logic [W-1:0] data;
    logic         valid;
    logic         last;
    logic         ready;

    modport master (output data, output valid, output last, input ready);
    modport slave  (input data, input valid, input last, output ready);

endinterface

// File: rtl/demosaic_round_sat.sv
// Combinational round-half-up, right shift and clip of an accumulated sum to
// an output pixel component, flagging when the clip was applied.
module demosaic_round_sat
    import demosaic_pkg::*;
#(
    parameter int ACC_W = PROD_W_DEF + 2,
    parameter int SHIFT = SHIFT_DEF,
    parameter int OUT_W = OUT_W_DEF
) (
    input  logic [ACC_W-1:0] i_sum,
    output logic [OUT_W-1:0] o_pix,
    output logic             o_sat
);

    // One spare bit so adding the half-LSB never wraps.
    localparam int             RW   = ACC_W + 1;
    localparam logic [RW-1:0]  HALF = RW'(1) << (SHIFT - 1);
    localparam logic [RW-1:0]  MAXV = RW'((1 << OUT_W) - 1);

    function automatic logic [RW-1:0] round_shift(input logic [ACC_W-1:0] s);
        return ({1'b0, s} + HALF) >> SHIFT;
    endfunction

    function automatic logic is_sat(input logic [RW-1:0] r);
        return r > MAXV;
    endfunction

    function automatic logic [OUT_W-1:0] clip(input logic [RW-1:0] r);
        return is_sat(r) ? OUT_W'(MAXV) : r[OUT_W-1:0];
    endfunction

    logic [RW-1:0] w_r;

    assign w_r   = round_shift(i_sum);
    assign o_sat = is_sat(w_r);
    assign o_pix = clip(w_r);

endmodule

// File: rtl/demosaic_wsum_norm.sv
// Accumulates the weighted neighbour products of one colour sample, then
// rounds, shifts and saturates the sum into a pixel component.
module demosaic_wsum_norm
    import demosaic_pkg::*;
#(
    parameter int PROD_W    = PROD_W_DEF,
    parameter int TERMS_MAX = TERMS_MAX_DEF,
    parameter int SHIFT     = SHIFT_DEF,
    parameter int OUT_W     = OUT_W_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst_n,
    demosaic_wsum_norm_if.slave  prod,
    demosaic_wsum_norm_if.master pix,
    output logic                 err_overrun,
    output logic [15:0]          sat_count
);

    localparam int              ACC_W    = PROD_W + clog2(TERMS_MAX);
    localparam int              CNT_W    = (clog2(TERMS_MAX) > 0) ? clog2(TERMS_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TERMS_MAX - 1);

    logic [1:0]       r_rst_sync;
    logic             w_rst_n;

    logic [ACC_W-1:0] r_acc_p0;
    logic [CNT_W-1:0] r_cnt_p0;
    logic [ACC_W-1:0] w_sum_p0;
    logic             w_accept;
    logic             w_cnt_full;
    logic             w_close;

    logic [ACC_W-1:0] r_sum_p1;
    logic             r_vld_p1;
    logic [OUT_W-1:0] w_pix_p1;
    logic             w_sat_p1;

    logic [OUT_W-1:0] r_pix_p2;
    logic             r_vld_p2;

    logic             w_out_free;
    logic             w_b_free;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_rst_sync <= 2'b00;
        else           r_rst_sync <= {r_rst_sync[0], 1'b1};
    end

    assign w_rst_n = r_rst_sync[1];

    assign w_out_free = ~r_vld_p2 | pix.ready;
    assign w_b_free   = ~r_vld_p1 | w_out_free;
    assign prod.ready = w_rst_n & w_b_free;

    assign w_accept   = prod.valid & prod.ready;
    assign w_cnt_full = (r_cnt_p0 == CNT_LAST);
    assign w_close    = prod.last | w_cnt_full;
    assign w_sum_p0   = (r_cnt_p0 == '0) ? ACC_W'(prod.data)
                                         : r_acc_p0 + ACC_W'(prod.data);

    // ---- stage p0: accumulate terms of the open group ----
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_acc_p0    <= '0;
            r_cnt_p0    <= '0;
            err_overrun <= 1'b0;
        end else if (w_accept) begin
            if (w_close) begin
                r_cnt_p0 <= '0;
            end else begin
                r_cnt_p0 <= r_cnt_p0 + CNT_W'(1);
                r_acc_p0 <= w_sum_p0;
            end
            if (w_cnt_full && !prod.last) err_overrun <= 1'b1;
        end
    end

    // ---- stage p1: closed-group sum awaiting normalisation ----
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_sum_p1 <= '0;
            r_vld_p1 <= 1'b0;
        end else if (w_accept && w_close) begin
            r_sum_p1 <= w_sum_p0;
            r_vld_p1 <= 1'b1;
        end else if (w_out_free) begin
            r_vld_p1 <= 1'b0;
        end
    end

    demosaic_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT),
        .OUT_W (OUT_W)
    ) u_round_sat (
        .i_sum (r_sum_p1),
        .o_pix (w_pix_p1),
        .o_sat (w_sat_p1)
    );

    // ---- stage p2: output register, held while downstream stalls ----
    always_ff @(posedge ap_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_pix_p2  <= '0;
            r_vld_p2  <= 1'b0;
            sat_count <= '0;
        end else if (w_out_free) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_pix_p2 <= w_pix_p1;
                if (w_sat_p1 && sat_count != 16'hFFFF) sat_count <= sat_count + 16'd1;
            end
        end
    end

    assign pix.data  = r_pix_p2;
    assign pix.valid = r_vld_p2;
    assign pix.last  = 1'b1;

endmodule

// File: tb/tb_demosaic_wsum_norm.sv
// Self-checking bench for demosaic_wsum_norm: directed cases plus random
// groups compared against an arithmetic reference of round/shift/clip.
module tb_demosaic_wsum_norm;
    import demosaic_pkg::*;

    localparam int TMO     = 4000;
    localparam int SHIFT   = 10;
    localparam int OUT_MAX = 255;

    logic        ap_clk = 1'b0;
    logic        ap_rst_n = 1'b0;
    logic        err_overrun;
    logic [15:0] sat_count;

    demosaic_wsum_norm_if #(.W(25)) prod_if ();
    demosaic_wsum_norm_if #(.W(8))  pix_if ();

    demosaic_wsum_norm #(
        .PROD_W    (25),
        .TERMS_MAX (4),
        .SHIFT     (SHIFT),
        .OUT_W     (8)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .prod        (prod_if),
        .pix         (pix_if),
        .err_overrun (err_overrun),
        .sat_count   (sat_count)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pix_mode = 0;
    int got_q[$];
    int got_t[$];
    int exp_q[$];
    int exp_sat = 0;

    always #5 ap_clk = ~ap_clk;

    always @(posedge ap_clk) cyc <= cyc + 1;

    // Downstream: drive pix ready, record every pixel that will transfer.
    initial begin
        pix_if.ready = 1'b0;
        forever begin
            @(negedge ap_clk);
            case (pix_mode)
                0:       pix_if.ready = 1'b1;
                1:       pix_if.ready = ($urandom_range(0, 9) < 7);
                default: pix_if.ready = 1'b0;
            endcase
            #1;
            if (ap_rst_n && pix_if.valid && pix_if.ready) begin
                got_q.push_back(int'(pix_if.data));
                got_t.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input longint sum);
        longint r;
        r = (sum + (longint'(1) << (SHIFT - 1))) >> SHIFT;
        if (r > OUT_MAX) begin
            r = OUT_MAX;
            if (exp_sat < 65535) exp_sat++;
        end
        exp_q.push_back(int'(r));
    endtask

    task automatic send(input prod_t d, input logic l, input bit rnd);
        int n;
        n = 0;
        if (rnd) while ($urandom_range(0, 3) == 0) @(negedge ap_clk);
        @(negedge ap_clk);
        prod_if.data  = d;
        prod_if.last  = l;
        prod_if.valid = 1'b1;
        #1;
        while (!prod_if.ready && n < TMO) begin
            @(negedge ap_clk);
            #1;
            n++;
        end
        if (n >= TMO) chk("accept_timeout", 32'(prod_if.ready), 32'd1);
        @(posedge ap_clk);
        #1;
        prod_if.valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (got_q.size() < exp_q.size() && n < TMO * 4) begin
            @(negedge ap_clk);
            n++;
        end
        repeat (4) @(negedge ap_clk);
        #2;
        chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && got_q.size() > 0)
            chk({tag, "_data"}, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        chk({tag, "_sat"}, 32'(sat_count), 32'(exp_sat));
    endtask

    initial begin
        int    acc_n;
        int    nt;
        longint sum;
        prod_t d;

        prod_if.valid = 1'b0;
        prod_if.data  = '0;
        prod_if.last  = 1'b0;

        // Reset state
        repeat (3) @(negedge ap_clk);
        #1;
        chk("rst_pix_valid", 32'(pix_if.valid), 32'd0);
        chk("rst_pix_data", 32'(pix_if.data), 32'd0);
        chk("rst_err", 32'(err_overrun), 32'd0);
        chk("rst_sat", 32'(sat_count), 32'd0);
        chk("rst_prod_ready", 32'(prod_if.ready), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        repeat (3) @(negedge ap_clk);
        #1;
        chk("run_prod_ready", 32'(prod_if.ready), 32'd1);

        // Round-half-up boundary and two-cycle latency
        send(prod_t'(512), 1'b0, 1'b0);
        send(prod_t'(0), 1'b0, 1'b0);
        send(prod_t'(0), 1'b0, 1'b0);
        send(prod_t'(0), 1'b1, 1'b0);
        push_exp(512);
        @(negedge ap_clk);
        #1;
        chk("lat_t1_valid", 32'(pix_if.valid), 32'd0);
        @(negedge ap_clk);
        #1;
        chk("lat_t2_valid", 32'(pix_if.valid), 32'd1);
        chk("round_up_512", 32'(pix_if.data), 32'd1);
        send(prod_t'(511), 1'b0, 1'b0);
        send(prod_t'(0), 1'b0, 1'b0);
        send(prod_t'(0), 1'b0, 1'b0);
        send(prod_t'(0), 1'b1, 1'b0);
        push_exp(511);
        drain("round");

        // Saturation
        for (int i = 0; i < 4; i++) send(prod_t'(1 << 24), (i == 3), 1'b0);
        push_exp(longint'(4) << 24);
        drain("sat");
        chk("sat_no_err", 32'(err_overrun), 32'd0);

        // Forced close at TERMS_MAX without last
        for (int i = 0; i < 4; i++) send(prod_t'(1024), 1'b0, 1'b0);
        push_exp(4096);
        send(prod_t'(1024), 1'b1, 1'b0);
        push_exp(1024);
        drain("overrun");
        chk("overrun_err", 32'(err_overrun), 32'd1);

        // Downstream stall: two groups buffer, then back-pressure
        pix_mode = 2;
        acc_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            prod_if.data  = prod_t'((acc_n + 1) * 1024);
            prod_if.last  = 1'b1;
            prod_if.valid = 1'b1;
            #1;
            if (prod_if.ready) begin
                push_exp(longint'((acc_n + 1) * 1024));
                acc_n++;
            end
            @(posedge ap_clk);
            #1;
        end
        chk("stall_accepted", 32'(acc_n), 32'd2);
        chk("stall_prod_ready", 32'(prod_if.ready), 32'd0);
        chk("stall_hold_valid", 32'(pix_if.valid), 32'd1);
        chk("stall_hold_data", 32'(pix_if.data), 32'd1);
        prod_if.valid = 1'b0;
        pix_mode = 0;
        for (int i = 3; i <= 5; i++) begin
            send(prod_t'(i * 1024), 1'b1, 1'b0);
            push_exp(longint'(i * 1024));
        end
        drain("stall");

        // Full throughput: one pixel per cycle
        for (int i = 0; i < 8; i++) begin
            send(prod_t'(i * 1024 + 100), 1'b1, 1'b0);
            push_exp(longint'(i * 1024 + 100));
        end
        repeat (6) @(negedge ap_clk);
        #2;
        chk("thru_outputs", 32'(got_t.size()), 32'd8);
        if (got_t.size() == 8) chk("thru_span", 32'(got_t[7] - got_t[0]), 32'd7);
        drain("thru");

        // Random groups with random valid/ready
        pix_mode = 1;
        for (int g = 0; g < 1000; g++) begin
            nt = $urandom_range(1, 4);
            sum = 0;
            for (int t = 0; t < nt; t++) begin
                d = ($urandom_range(0, 3) == 0) ? prod_t'($urandom) : prod_t'($urandom_range(0, 70000));
                sum += longint'(d);
                send(d, (t == nt - 1), 1'b1);
            end
            push_exp(sum);
        end
        drain("rand");

        // Reset mid-group with an output pending
        pix_mode = 2;
        send(prod_t'(1024), 1'b1, 1'b0);
        send(prod_t'(2048), 1'b0, 1'b0);
        repeat (2) @(negedge ap_clk);
        #1;
        chk("pre_rst_valid", 32'(pix_if.valid), 32'd1);
        #1;
        ap_rst_n = 1'b0;
        #1;
        chk("mid_rst_pix_valid", 32'(pix_if.valid), 32'd0);
        chk("mid_rst_prod_ready", 32'(prod_if.ready), 32'd0);
        chk("mid_rst_err", 32'(err_overrun), 32'd0);
        got_q.delete();
        got_t.delete();
        exp_q.delete();
        exp_sat = 0;
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        pix_mode = 0;
        repeat (3) @(negedge ap_clk);
        send(prod_t'(1024), 1'b1, 1'b0);
        push_exp(1024);
        drain("post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
